// File: rtl/dtfag_seq_ctrl.sv
// DTFAG twiddle-address sequencer: walks (j, i, t) digits per FFT stage under a
// start/done handshake with valid/ready backpressure toward DTFAG_AGU.
module dtfag_seq_ctrl #(
   parameter int RADIX_W   = 4,
   parameter int NUM_STAGE = 4,
   parameter int STG_W     = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic [STG_W:0]     cfg_stage_num,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [RADIX_W-1:0] DTFAG_i,
   output logic [RADIX_W-1:0] DTFAG_t,
   output logic [RADIX_W-1:0] DTFAG_j,
   output logic               ROM_CEN,
   output logic [STG_W-1:0]   stage_idx,
   output logic               busy,
   output logic               done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t               state_q;
   logic [RADIX_W-1:0]   i_q;
   logic [RADIX_W-1:0]   t_q;
   logic [RADIX_W-1:0]   j_q;
   logic [STG_W-1:0]     stage_q;
   logic [STG_W-1:0]     last_q;
   logic [STG_W-1:0]     last_d;
   logic                 valid_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 xfer;
   logic                 t_max;
   logic                 i_max;
   logic                 j_max;

   // An abort in the same cycle suppresses the transfer, so the ROM stays disabled.
   assign xfer  = valid_q & out_ready & ~stop;
   assign t_max = (t_q == '1);
   assign i_max = (i_q == '1);
   assign j_max = (j_q == '1);

   // Stage count 0 behaves as 1; anything above NUM_STAGE saturates.
   always_comb begin
      last_d = '0;
      if (cfg_stage_num == '0) begin
         last_d = '0;
      end else if (cfg_stage_num > (STG_W+1)'(NUM_STAGE)) begin
         last_d = STG_W'(NUM_STAGE - 1);
      end else begin
         last_d = STG_W'(cfg_stage_num - 1'b1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         i_q     <= '0;
         t_q     <= '0;
         j_q     <= '0;
         stage_q <= '0;
         last_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (stop) begin
         state_q <= S_IDLE;
         i_q     <= '0;
         t_q     <= '0;
         j_q     <= '0;
         stage_q <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q <= S_RUN;
                  i_q     <= '0;
                  t_q     <= '0;
                  j_q     <= '0;
                  stage_q <= '0;
                  last_q  <= last_d;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            S_RUN: begin
               if (xfer) begin
                  if (!t_max) begin
                     t_q <= t_q + 1'b1;
                  end else if (!i_max) begin
                     t_q <= '0;
                     i_q <= i_q + 1'b1;
                  end else if (!j_max) begin
                     t_q <= '0;
                     i_q <= '0;
                     j_q <= j_q + 1'b1;
                  end else if (stage_q != last_q) begin
                     t_q     <= '0;
                     i_q     <= '0;
                     j_q     <= '0;
                     stage_q <= stage_q + 1'b1;
                  end else begin
                     state_q <= S_DONE;
                     valid_q <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = valid_q;
   assign DTFAG_i   = i_q;
   assign DTFAG_t   = t_q;
   assign DTFAG_j   = j_q;
   assign stage_idx = stage_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign ROM_CEN   = ~xfer;

endmodule

// File: tb/tb_dtfag_seq_ctrl.sv
// Self-checking bench for dtfag_seq_ctrl: a checkpoint table for the single-stage
// walk plus directed sequences for backpressure, multi-stage, abort and reset.
module tb_dtfag_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       stop;
   logic [2:0] cfg_stage_num;
   logic       out_ready;
   logic       out_valid;
   logic [3:0] DTFAG_i;
   logic [3:0] DTFAG_t;
   logic [3:0] DTFAG_j;
   logic       ROM_CEN;
   logic [1:0] stage_idx;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   dtfag_seq_ctrl #(.RADIX_W(4), .NUM_STAGE(4), .STG_W(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .stop          (stop),
      .cfg_stage_num (cfg_stage_num),
      .out_ready     (out_ready),
      .out_valid     (out_valid),
      .DTFAG_i       (DTFAG_i),
      .DTFAG_t       (DTFAG_t),
      .DTFAG_j       (DTFAG_j),
      .ROM_CEN       (ROM_CEN),
      .stage_idx     (stage_idx),
      .busy          (busy),
      .done          (done)
   );

   typedef struct {
      int         cyc;
      logic       valid;
      logic       dn;
      logic       cen;
      logic [3:0] j;
      logic [3:0] i;
      logic [3:0] t;
   } vec_t;

   // Snapshot packing: {valid, done, cen, busy, j, i, t}
   logic [15:0] snap [0:4100];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Drives one full sequence against an independent digit model.
   task automatic run_seq(input logic [2:0] cfg, input bit toggle, input int exp_xfers,
                          input string name);
      int  ej, ei, et, es, stages, xfers, cen_low, mism, budget;
      bit  fin;
      stages = exp_xfers / 4096;
      ej = 0; ei = 0; et = 0; es = 0;
      xfers = 0; cen_low = 0; mism = 0; fin = 0;
      budget = exp_xfers * 2 + 10;
      cfg_stage_num = cfg;
      out_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      cfg_stage_num = 3'd7;
      for (int cyc = 1; cyc < budget && !fin; cyc++) begin
         out_ready = toggle ? logic'(cyc % 2) : 1'b1;
         start = (cyc == 37);
         #1;
         if (ROM_CEN == 1'b0) cen_low++;
         if (!(out_valid && busy && !done && DTFAG_j == 4'(ej) && DTFAG_i == 4'(ei) &&
               DTFAG_t == 4'(et) && stage_idx == 2'(es) && ROM_CEN == !out_ready)) begin
            if (mism == 0)
               $display("%s first divergence at cycle %0d: got v=%b j=%0d i=%0d t=%0d s=%0d cen=%b, model j=%0d i=%0d t=%0d s=%0d",
                        name, cyc, out_valid, DTFAG_j, DTFAG_i, DTFAG_t, stage_idx, ROM_CEN,
                        ej, ei, et, es);
            mism++;
         end
         if (out_ready) begin
            xfers++;
            if (et != 15) et++;
            else begin
               et = 0;
               if (ei != 15) ei++;
               else begin
                  ei = 0;
                  if (ej != 15) ej++;
                  else begin
                     ej = 0;
                     if (es == stages - 1) fin = 1;
                     else es++;
                  end
               end
            end
         end
         step();
         start = 1'b0;
      end
      chk({name, "_finished"}, 32'(fin), 32'd1);
      chk({name, "_seq_mismatches"}, 32'(mism), 32'd0);
      chk({name, "_transfers"}, 32'(xfers), 32'(exp_xfers));
      chk({name, "_rom_cen_low"}, 32'(cen_low), 32'(exp_xfers));
      // DONE cycle; a start here must not be queued
      out_ready = 1'b1;
      start = 1'b1;
      #1;
      chk({name, "_done_pulse"}, {28'd0, done, out_valid, busy, ROM_CEN}, 32'b1001);
      step();
      start = 1'b0;
      #1;
      chk({name, "_after_done"}, {28'd0, done, out_valid, busy, ROM_CEN}, 32'b0001);
      chk({name, "_hold_digits"}, {22'd0, stage_idx, DTFAG_j, DTFAG_i, DTFAG_t},
          {22'd0, 2'(stages - 1), 12'hFFF});
      step();
      chk({name, "_start_in_done_ignored"}, {30'd0, out_valid, done}, 32'd0);
   endtask

   vec_t vecs [9];

   initial begin
      vecs[0] = '{1,    1'b1, 1'b0, 1'b0, 4'd0,  4'd0,  4'd0};
      vecs[1] = '{2,    1'b1, 1'b0, 1'b0, 4'd0,  4'd0,  4'd1};
      vecs[2] = '{16,   1'b1, 1'b0, 1'b0, 4'd0,  4'd0,  4'd15};
      vecs[3] = '{17,   1'b1, 1'b0, 1'b0, 4'd0,  4'd1,  4'd0};
      vecs[4] = '{256,  1'b1, 1'b0, 1'b0, 4'd0,  4'd15, 4'd15};
      vecs[5] = '{257,  1'b1, 1'b0, 1'b0, 4'd1,  4'd0,  4'd0};
      vecs[6] = '{4096, 1'b1, 1'b0, 1'b0, 4'd15, 4'd15, 4'd15};
      vecs[7] = '{4097, 1'b0, 1'b1, 1'b1, 4'd15, 4'd15, 4'd15};
      vecs[8] = '{4098, 1'b0, 1'b0, 1'b1, 4'd15, 4'd15, 4'd15};

      rst = 1'b1; start = 1'b0; stop = 1'b0; cfg_stage_num = 3'd1; out_ready = 1'b1;
      step();
      step();
      chk("reset_ctrl", {28'd0, out_valid, ROM_CEN, busy, done}, 32'b0100);
      chk("reset_digits", {22'd0, stage_idx, DTFAG_j, DTFAG_i, DTFAG_t}, 32'd0);
      rst = 1'b0;
      step();

      // Single-stage walk captured per cycle, then checked against the table
      cfg_stage_num = 3'd1;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int cyc = 1; cyc <= 4100; cyc++) begin
         #1;
         snap[cyc] = {out_valid, done, ROM_CEN, busy, DTFAG_j, DTFAG_i, DTFAG_t};
         step();
      end
      for (int k = 0; k < 9; k++) begin
         chk($sformatf("walk_cyc%0d", vecs[k].cyc), 32'(snap[vecs[k].cyc]),
             32'({vecs[k].valid, vecs[k].dn, vecs[k].cen, vecs[k].valid,
                  vecs[k].j, vecs[k].i, vecs[k].t}));
      end

      run_seq(3'd4, 1'b0, 16384, "four_stage");
      run_seq(3'd1, 1'b1, 4096, "toggle_ready");
      run_seq(3'd0, 1'b0, 4096, "cfg_zero");
      run_seq(3'd5, 1'b0, 16384, "cfg_clamp");

      // Abort in stage 1 at (3,7,9): 4096 + 889 transfers precede it
      cfg_stage_num = 3'd2;
      out_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k < 4986; k++) step();
      chk("stop_point", {22'd0, stage_idx, DTFAG_j, DTFAG_i, DTFAG_t}, {22'd0, 2'd1, 12'h379});
      stop = 1'b1;
      #1;
      chk("stop_cycle_rom_cen", 32'(ROM_CEN), 32'd1);
      step();
      stop = 1'b0;
      chk("stop_idle", {28'd0, out_valid, busy, done, ROM_CEN}, 32'b0001);
      chk("stop_cleared", {22'd0, stage_idx, DTFAG_j, DTFAG_i, DTFAG_t}, 32'd0);
      begin
         int dn_seen = 0;
         for (int k = 0; k < 4; k++) begin
            if (done) dn_seen++;
            step();
         end
         chk("stop_no_done", 32'(dn_seen), 32'd0);
      end
      start = 1'b1;
      step();
      start = 1'b0;
      chk("restart_first", {19'd0, out_valid, ROM_CEN, stage_idx, DTFAG_j, DTFAG_i, DTFAG_t},
          {19'd0, 1'b1, 1'b0, 14'd0});
      step();
      chk("restart_second", {20'd0, DTFAG_j, DTFAG_i, DTFAG_t}, 32'h001);

      // Reset mid-sequence: back to idle, no done
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_mid_run", {28'd0, out_valid, busy, done, ROM_CEN}, 32'b0001);
      chk("rst_mid_digits", {22'd0, stage_idx, DTFAG_j, DTFAG_i, DTFAG_t}, 32'd0);

      // start and stop together in IDLE
      start = 1'b1;
      stop = 1'b1;
      step();
      start = 1'b0;
      stop = 1'b0;
      chk("start_stop_idle", {29'd0, out_valid, busy, done}, 32'd0);
      step();
      chk("start_stop_idle_2", {29'd0, out_valid, busy, done}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete, expected completion");
      $fatal(1, "timeout");
   end

endmodule
